avalon_pio_gpio: RTL

Parametrised Avalon-MM slave PIO that supersedes the fixed 8-bit output-only LCD control port.
- Per-bit direction control, atomic bit set/clear, synchronised input sampling.
- Programmable edge capture with maskable interrupt.
- Sits on the Nios II system bus and drives LCD control/data pins or general GPIO.

---
 rtl/pio_pkg.sv | 15 +
 rtl/gpio_sync.sv | 17 +
 rtl/avalon_pio_gpio.sv | 76 +++++++
 3 files changed

// File: rtl/pio_pkg.sv
// pio_pkg: shared register map, edge-mode codes and bus width for the PIO slave.
package pio_pkg;
  localparam int BUS_W = 32;
  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5
  } addr_e;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH-bit multi-stage input synchroniser with asynchronous reset.
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/avalon_pio_gpio.sv
// avalon_pio_gpio: Avalon-MM PIO with per-bit direction, set/clear, edge capture and maskable irq.
module avalon_pio_gpio
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [BUS_W-1:0] writedata,
  output logic [BUS_W-1:0] readdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  logic [WIDTH-1:0] data_q, data_d, dir_q, dir_d, mask_q, mask_d, edge_q, edge_d;
  logic [WIDTH-1:0] prev_q, sync_in, ev, wd, rd;
  logic [AW-1:0]    arm_q, arm_d;
  logic             wr, armed, unused_wd;
  gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (gpio_in),
    .q      (sync_in)
  );
  always_comb begin
    wd        = writedata[WIDTH-1:0];
    unused_wd = ^writedata;
    wr        = chipselect & ~write_n;
    armed     = arm_q == AW'(SYNC_STAGES + 1);
    arm_d     = armed ? arm_q : arm_q + 1'b1;
    ev        = EDGE_TYPE == EDGE_RISE ? sync_in & ~prev_q :
                EDGE_TYPE == EDGE_FALL ? ~sync_in & prev_q : sync_in ^ prev_q;
    data_d    = !wr                      ? data_q :
                address == ADDR_DATA     ? wd :
                address == ADDR_OUTSET   ? data_q | wd :
                address == ADDR_OUTCLR   ? data_q & ~wd : data_q;
    dir_d     = wr && address == ADDR_DIR ? wd : dir_q;
    mask_d    = wr && address == ADDR_IRQMASK ? wd : mask_q;
    // A new edge on a bit overrides a same-cycle write-1-to-clear.
    edge_d    = (edge_q & ~(wr && address == ADDR_EDGECAP ? wd : '0)) |
                (armed ? ev & ~dir_q : '0);
    rd        = address == ADDR_DATA    ? (data_q & dir_q) | (sync_in & ~dir_q) :
                address == ADDR_DIR     ? dir_q :
                address == ADDR_IRQMASK ? mask_q :
                address == ADDR_EDGECAP ? edge_q : '0;
    readdata  = BUS_W'(rd);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= DIR_RESET;
      mask_q <= '0;
      edge_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      prev_q <= sync_in;
      arm_q  <= arm_d;
    end
  assign gpio_out = data_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(edge_q & mask_q);
endmodule
